rd_ptr_ctrl: RTL and testbench

Read-side pointer and flag controller for the parameterised asynchronous FIFO, the next generation of the read-pointer logic. It synchronises the write-domain Gray pointer internally, maintains binary and Gray read pointers, and produces a registered fill level. It also generates registered empty and programmable almost-empty flags, and optional underflow diagnostics. It sits in the read clock domain between the dual-port RAM read port and the write-domain pointer logic.

---
 rtl/fifo_pkg.sv | 27 ++
 rtl/rd_ptr_ctrl_if.sv | 24 ++
 rtl/ptr_sync.sv | 35 +++
 rtl/rd_ptr_ctrl.sv | 93 +++++++++
 tb/tb_rd_ptr_ctrl.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// Shared FIFO helpers: Gray/binary conversion, underflow counter width and
// synchroniser depth limits, imported by both pointer controllers.
package fifo_pkg;

  localparam int unsigned UF_CNT_W        = 8;
  localparam int unsigned SYNC_STAGES_MIN = 2;
  localparam int unsigned SYNC_STAGES_MAX = 4;

  // Conversions work on a wide container; callers zero-extend their pointer
  // in and truncate the result, so any width up to CODE_MAX_W is supported.
  localparam int unsigned CODE_MAX_W = 32;
  typedef logic [CODE_MAX_W-1:0] code_t;

  function automatic code_t bin2gray(input code_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic code_t gray2bin(input code_t g);
    code_t b;
    b = '0;
    for (int unsigned i = 0; i < CODE_MAX_W; i++) begin
      b[i] = ^(g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/rd_ptr_ctrl_if.sv
// Consumer-facing read port of the FIFO: request in, address/level/flags out.
interface rd_ptr_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 4
);

  logic                          rd_en;
  logic [ADDR_WIDTH-1:0]         rd_addr;
  logic [ADDR_WIDTH:0]           rd_level;
  logic                          empty;
  logic                          almost_empty;
  logic                          underflow;
  logic [fifo_pkg::UF_CNT_W-1:0] uf_count;

  modport master (
    output rd_en,
    input  rd_addr, rd_level, empty, almost_empty, underflow, uf_count
  );

  modport slave (
    input  rd_en,
    output rd_addr, rd_level, empty, almost_empty, underflow, uf_count
  );

endinterface

// File: rtl/ptr_sync.sv
// Multi-flop synchroniser for a Gray pointer crossing into this clock domain.
module ptr_sync
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH  = 5,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (STAGES < SYNC_STAGES_MIN || STAGES > SYNC_STAGES_MAX) begin : g_bad_stages
    $error("ptr_sync: STAGES must be within 2..4");
  end

  logic [WIDTH-1:0] sync_q [STAGES];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= d;
      for (int unsigned i = 1; i < STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/rd_ptr_ctrl.sv
// Read-side pointer/flag controller of the async FIFO.
// Optional underflow diagnostics: define RD_PTR_CTRL_UNDERFLOW_EN.
module rd_ptr_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                rd_clk,
  input  logic                rd_rst,
  rd_ptr_ctrl_if.slave        bus,
  input  logic [ADDR_WIDTH:0] wr_ptr_gray,
  input  logic [ADDR_WIDTH:0] ae_thresh,
  output logic [ADDR_WIDTH:0] rd_ptr_gray
);

  localparam int unsigned PTR_W = ADDR_WIDTH + 1;
  typedef logic [PTR_W-1:0] ptr_t;

  ptr_t rd_ptr_bin;
  ptr_t rd_ptr_bin_nxt;
  ptr_t wr_gray_s;
  ptr_t wr_bin_s;
  ptr_t level_nxt;
  ptr_t rd_level_q;
  logic empty_q;
  logic almost_empty_q;
  logic pop;

  ptr_sync #(
    .WIDTH  (PTR_W),
    .STAGES (SYNC_STAGES)
  ) u_wr_sync (
    .clk (rd_clk),
    .rst (rd_rst),
    .d   (wr_ptr_gray),
    .q   (wr_gray_s)
  );

  // Level and flags use the post-pop pointer so a pop is reflected on the
  // same edge it is accepted; pointer arithmetic is modulo 2**PTR_W.
  always_comb begin
    wr_bin_s       = ptr_t'(gray2bin(code_t'(wr_gray_s)));
    pop            = bus.rd_en && !empty_q;
    rd_ptr_bin_nxt = rd_ptr_bin + ptr_t'(pop);
    level_nxt      = wr_bin_s - rd_ptr_bin_nxt;
  end

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      rd_ptr_bin     <= '0;
      rd_ptr_gray    <= '0;
      rd_level_q     <= '0;
      empty_q        <= 1'b1;
      almost_empty_q <= 1'b1;
    end else begin
      rd_ptr_bin     <= rd_ptr_bin_nxt;
      rd_ptr_gray    <= ptr_t'(bin2gray(code_t'(rd_ptr_bin_nxt)));
      rd_level_q     <= level_nxt;
      empty_q        <= (level_nxt == '0);
      almost_empty_q <= (level_nxt <= ae_thresh);
    end
  end

  assign bus.rd_addr      = rd_ptr_bin[ADDR_WIDTH-1:0];
  assign bus.rd_level     = rd_level_q;
  assign bus.empty        = empty_q;
  assign bus.almost_empty = almost_empty_q;

`ifdef RD_PTR_CTRL_UNDERFLOW_EN
  logic                underflow_q;
  logic [UF_CNT_W-1:0] uf_count_q;

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      underflow_q <= 1'b0;
      uf_count_q  <= '0;
    end else if (bus.rd_en && empty_q) begin
      underflow_q <= 1'b1;
      if (uf_count_q != '1) begin
        uf_count_q <= uf_count_q + UF_CNT_W'(1);
      end
    end
  end

  assign bus.underflow = underflow_q;
  assign bus.uf_count  = uf_count_q;
`else
  assign bus.underflow = 1'b0;
  assign bus.uf_count  = '0;
`endif

endmodule

// File: tb/tb_rd_ptr_ctrl.sv
// Bench for rd_ptr_ctrl: directed scenarios plus randomized traffic checked
// every cycle against an occupancy model built from total write/read counts.
module tb_rd_ptr_ctrl;

  localparam int AW    = 4;
  localparam int PW    = AW + 1;
  localparam int DEPTH = 1 << AW;
  localparam int SS    = 2;
`ifdef RD_PTR_CTRL_UNDERFLOW_EN
  localparam bit UF_EN = 1'b1;
`else
  localparam bit UF_EN = 1'b0;
`endif

  logic          rd_clk = 1'b0;
  logic          rd_rst;
  logic [PW-1:0] wr_ptr_gray;
  logic [PW-1:0] ae_thresh;
  logic [PW-1:0] rd_ptr_gray;

  rd_ptr_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

  rd_ptr_ctrl #(
    .ADDR_WIDTH  (AW),
    .SYNC_STAGES (SS)
  ) dut (
    .rd_clk      (rd_clk),
    .rd_rst      (rd_rst),
    .bus         (bus.slave),
    .wr_ptr_gray (wr_ptr_gray),
    .ae_thresh   (ae_thresh),
    .rd_ptr_gray (rd_ptr_gray)
  );

  always #5 rd_clk = ~rd_clk;

  int vectors     = 0;
  int miscompares = 0;
  bit check_en    = 1'b0;

  // model state: total entries written / popped, unbounded integers
  int wr_total = 0;
  int m_rd     = 0;
  int m_level  = 0;
  bit m_empty  = 1'b1;
  bit m_ae     = 1'b1;
  bit m_uf     = 1'b0;
  int m_ufc    = 0;
  bit m_popped = 1'b0;
  bit m_rst_edge = 1'b1;
  int hist[$];

  function automatic logic [PW-1:0] gray_of(input int v);
    logic [PW-1:0] b;
    b = PW'(v % (2 * DEPTH));
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic push_wr();
    wr_total++;
    wr_ptr_gray = gray_of(wr_total);
  endtask

  // A write value sampled at edge N is counted in the level at edge N+SS.
  initial for (int i = 0; i < SS; i++) hist.push_back(0);

  always @(posedge rd_clk) begin
    int w_vis;
    m_rst_edge = rd_rst;
    if (rd_rst) begin
      m_rd = 0; m_level = 0; m_empty = 1'b1; m_ae = 1'b1;
      m_uf = 1'b0; m_ufc = 0; m_popped = 1'b0;
      hist = {};
      for (int i = 0; i < SS; i++) hist.push_back(0);
    end else begin
      m_popped = bus.rd_en && !m_empty;
      if (m_popped) m_rd++;
      else if (bus.rd_en) begin
        m_uf = 1'b1;
        if (m_ufc < 255) m_ufc++;
      end
      w_vis = hist.pop_front();
      hist.push_back(wr_total);
      m_level = w_vis - m_rd;
      m_empty = (m_level == 0);
      m_ae    = (m_level <= int'(ae_thresh));
    end
  end

  logic [PW-1:0] prev_gray = '0;
  always @(negedge rd_clk) begin
    if (check_en) begin
      check("rd_addr",      32'(bus.rd_addr),      32'(m_rd % DEPTH));
      check("rd_ptr_gray",  32'(rd_ptr_gray),      32'(gray_of(m_rd)));
      check("rd_level",     32'(bus.rd_level),     32'(m_level));
      check("empty",        32'(bus.empty),        32'(m_empty));
      check("almost_empty", 32'(bus.almost_empty), 32'(m_ae));
      check("underflow",    32'(bus.underflow),    UF_EN ? 32'(m_uf) : 32'd0);
      check("uf_count",     32'(bus.uf_count),     UF_EN ? 32'(m_ufc) : 32'd0);
      check("level_bound",  32'(bus.rd_level <= PW'(DEPTH)), 32'd1);
      if (!m_rst_edge)
        check("gray_step", 32'($countones(rd_ptr_gray ^ prev_gray)), m_popped ? 32'd1 : 32'd0);
      prev_gray = rd_ptr_gray;
    end
  end

  initial begin
    rd_rst = 1'b1; bus.rd_en = 1'b1; wr_ptr_gray = '0; ae_thresh = PW'(3);

    // reset with rd_en held high
    repeat (2) @(negedge rd_clk);
    check_en = 1'b1;
    check("rst_empty", 32'(bus.empty), 32'd1);
    check("rst_ae",    32'(bus.almost_empty), 32'd1);
    check("rst_level", 32'(bus.rd_level), 32'd0);
    check("rst_addr",  32'(bus.rd_addr), 32'd0);
    check("rst_gray",  32'(rd_ptr_gray), 32'd0);
    check("rst_ufc",   32'(bus.uf_count), 32'd0);
    rd_rst = 1'b0; bus.rd_en = 1'b0;

    // sync latency: single write sampled at edge N shows at N+2
    push_wr();
    @(negedge rd_clk);
    @(negedge rd_clk);
    check("sync_n1_empty", 32'(bus.empty), 32'd1);
    @(negedge rd_clk);
    check("sync_n2_empty", 32'(bus.empty), 32'd0);
    check("sync_n2_level", 32'(bus.rd_level), 32'd1);
    bus.rd_en = 1'b1;
    @(negedge rd_clk);
    bus.rd_en = 1'b0;
    check("pop_addr",  32'(bus.rd_addr), 32'd1);
    check("pop_gray",  32'(rd_ptr_gray), 32'b00001);
    check("pop_empty", 32'(bus.empty), 32'd1);

    // threshold: 8 entries, 5 pops, almost_empty rises at level 3
    for (int i = 0; i < 8; i++) begin
      push_wr();
      @(negedge rd_clk);
    end
    repeat (3) @(negedge rd_clk);
    check("thr_level8", 32'(bus.rd_level), 32'd8);
    check("thr_ae_lo",  32'(bus.almost_empty), 32'd0);
    for (int i = 0; i < 5; i++) begin
      bus.rd_en = 1'b1;
      @(negedge rd_clk);
      check("thr_pop_level", 32'(bus.rd_level), 32'(7 - i));
      check("thr_pop_ae",    32'(bus.almost_empty), (i == 4) ? 32'd1 : 32'd0);
    end
    bus.rd_en = 1'b0;

    // randomized traffic long enough to wrap the pointer several times
    for (int c = 0; c < 600; c++) begin
      if (c % 64 == 0) ae_thresh = PW'($urandom_range(0, 20));
      if ((wr_total - m_rd) < DEPTH && $urandom_range(0, 99) < 55) push_wr();
      bus.rd_en = ($urandom_range(0, 99) < 50);
      @(negedge rd_clk);
    end
    bus.rd_en = 1'b0;
    ae_thresh = PW'(3);

    // underflow: 300 reads while empty after a clean reset
    rd_rst = 1'b1; wr_total = 0; wr_ptr_gray = '0;
    @(negedge rd_clk);
    rd_rst = 1'b0;
    bus.rd_en = 1'b1;
    repeat (300) @(negedge rd_clk);
    bus.rd_en = 1'b0;
    check("uf_addr",  32'(bus.rd_addr), 32'd0);
    check("uf_flag",  32'(bus.underflow), UF_EN ? 32'd1 : 32'd0);
    check("uf_count", 32'(bus.uf_count), UF_EN ? 32'd255 : 32'd0);

    // mid-operation reset at level 6 with a pop requested
    rd_rst = 1'b1;
    @(negedge rd_clk);
    rd_rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      push_wr();
      @(negedge rd_clk);
    end
    repeat (3) @(negedge rd_clk);
    check("mid_level6", 32'(bus.rd_level), 32'd6);
    rd_rst = 1'b1; bus.rd_en = 1'b1; wr_total = 0; wr_ptr_gray = '0;
    @(negedge rd_clk);
    rd_rst = 1'b0; bus.rd_en = 1'b0;
    check("mid_level", 32'(bus.rd_level), 32'd0);
    check("mid_empty", 32'(bus.empty), 32'd1);
    check("mid_ae",    32'(bus.almost_empty), 32'd1);
    check("mid_addr",  32'(bus.rd_addr), 32'd0);
    check("mid_gray",  32'(rd_ptr_gray), 32'd0);
    check("mid_ufc",   32'(bus.uf_count), 32'd0);
    repeat (4) @(negedge rd_clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
